// File: rtl/amo_responder.sv
// amo_responder: executes one LR / SC / AMO read-modify-write at a time against a single-port 64-bit memory.
// Latency (zero-wait memory): RMW ack at c4, LR c3, SC success c2, SC fail / AMO_NONE c1; each gnt/rvalid stall adds one cycle.
// Backpressure: amo_req_i is only sampled in IDLE (one op in flight); mem_req_o is held until mem_gnt_i.
//
// Ports:
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   amo_req_i/op/size/addr/data : AMO request, held by the requester until amo_ack_o
//   amo_ack_o, amo_result_o     : one-cycle registered response (old value, or SC status 0/1)
//   mem_req_o .. mem_be_o       : registered memory request, held until mem_gnt_i
//   mem_rvalid_i, mem_rdata_i   : read return, at least one cycle after the read grant
//
// Build option: define AMO_RESERVATION_EN to include the LR/SC reservation register.
// Without it LR is a plain read and SC always fails at c1 without touching memory.
module amo_responder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        amo_req_i,
    input  logic [3:0]  amo_op_i,
    input  logic [1:0]  amo_size_i,
    input  logic [63:0] amo_addr_i,
    input  logic [63:0] amo_data_i,
    output logic        amo_ack_o,
    output logic [63:0] amo_result_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_be_o,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i
);
    // amo_t encoding
    localparam logic [3:0] AMO_NONE = 4'd0;
    localparam logic [3:0] AMO_LR   = 4'd1;
    localparam logic [3:0] AMO_SC   = 4'd2;
    localparam logic [3:0] AMO_SWAP = 4'd3;
    localparam logic [3:0] AMO_ADD  = 4'd4;
    localparam logic [3:0] AMO_AND  = 4'd5;
    localparam logic [3:0] AMO_OR   = 4'd6;
    localparam logic [3:0] AMO_XOR  = 4'd7;
    localparam logic [3:0] AMO_MAX  = 4'd8;
    localparam logic [3:0] AMO_MAXU = 4'd9;
    localparam logic [3:0] AMO_MIN  = 4'd10;
    localparam logic [3:0] AMO_MINU = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RDATA,
        WRITE,
        ACK
    } state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic        word_q;
    logic        hi_q;          // word lane, addr[2]
    logic [63:0] data_q;

    logic        amo_ack_q;
    logic [63:0] amo_result_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;
    logic [7:0]  mem_be_q;

    assign amo_ack_o    = amo_ack_q;
    assign amo_result_o = amo_result_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_be_o     = mem_be_q;

    // Sub-word offset bits carry no information here; alignment is checked upstream.
    logic unused_addr_bits;
    assign unused_addr_bits = ^amo_addr_i[1:0];

    // ------------------------------------------------------------------
    // Request decode, only consumed in IDLE
    // ------------------------------------------------------------------
    logic        req_word;
    logic        req_rmw;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;

    assign req_word  = (amo_size_i == 2'b10);
    assign req_rmw   = (amo_op_i >= AMO_SWAP) && (amo_op_i <= AMO_MINU);
    assign req_be    = req_word ? (amo_addr_i[2] ? 8'hF0 : 8'h0F) : 8'hFF;
    assign req_wdata = req_word ? {2{amo_data_i[31:0]}} : amo_data_i;

`ifdef AMO_RESERVATION_EN
    logic        resv_vld_q;
    logic [60:0] resv_addr_q;
    logic        resv_hit;

    // Match on doubleword address only; size is irrelevant.
    assign resv_hit = resv_vld_q && (resv_addr_q == amo_addr_i[63:3]);
`endif

    // ------------------------------------------------------------------
    // Read-modify-write datapath
    // ------------------------------------------------------------------
    logic [31:0] rd_lane;
    logic [63:0] old_val_d;
    logic [63:0] opb;
    logic [63:0] new_val_d;
    logic [63:0] wdata_d;

    assign rd_lane   = hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    assign old_val_d = word_q ? {{32{rd_lane[31]}}, rd_lane} : mem_rdata_i;
    // Word operands are sign-extended to 64 bits so one comparator serves both
    // widths: sign extension preserves both signed and unsigned 32-bit order,
    // and the low 32 bits of the 64-bit sum equal the 32-bit wrapped sum.
    assign opb       = word_q ? {{32{data_q[31]}}, data_q[31:0]} : data_q;

    always_comb begin
        new_val_d = opb;
        case (op_q)
            AMO_ADD:  new_val_d = old_val_d + opb;
            AMO_AND:  new_val_d = old_val_d & opb;
            AMO_OR:   new_val_d = old_val_d | opb;
            AMO_XOR:  new_val_d = old_val_d ^ opb;
            AMO_MAX:  new_val_d = ($signed(old_val_d) > $signed(opb)) ? old_val_d : opb;
            AMO_MAXU: new_val_d = (old_val_d > opb) ? old_val_d : opb;
            AMO_MIN:  new_val_d = ($signed(old_val_d) < $signed(opb)) ? old_val_d : opb;
            AMO_MINU: new_val_d = (old_val_d < opb) ? old_val_d : opb;
            default:  new_val_d = opb;   // SWAP
        endcase
    end

    // The new word is replicated so the byte enables alone pick the lane.
    assign wdata_d = word_q ? {2{new_val_d[31:0]}} : new_val_d;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            op_q         <= AMO_NONE;
            word_q       <= 1'b0;
            hi_q         <= 1'b0;
            data_q       <= '0;
            amo_ack_q    <= 1'b0;
            amo_result_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
`ifdef AMO_RESERVATION_EN
            resv_vld_q   <= 1'b0;
            resv_addr_q  <= '0;
`endif
        end else begin
            amo_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (amo_req_i) begin
                        op_q       <= amo_op_i;
                        word_q     <= req_word;
                        hi_q       <= amo_addr_i[2];
                        data_q     <= amo_data_i;
                        mem_addr_q <= {amo_addr_i[63:3], 3'b000};
                        mem_be_q   <= req_be;
                        if (amo_op_i == AMO_LR || req_rmw) begin
                            state_q   <= READ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
`ifdef AMO_RESERVATION_EN
                            if (amo_op_i == AMO_LR) begin
                                resv_vld_q  <= 1'b1;
                                resv_addr_q <= amo_addr_i[63:3];
                            end else if (resv_hit) begin
                                resv_vld_q  <= 1'b0;
                            end
`endif
                        end else if (amo_op_i == AMO_SC) begin
`ifdef AMO_RESERVATION_EN
                            // Any SC consumes the reservation, pass or fail.
                            resv_vld_q <= 1'b0;
                            if (resv_hit) begin
                                state_q      <= WRITE;
                                mem_req_q    <= 1'b1;
                                mem_we_q     <= 1'b1;
                                mem_wdata_q  <= req_wdata;
                                amo_result_q <= 64'd0;
                            end else begin
                                state_q      <= ACK;
                                amo_ack_q    <= 1'b1;
                                amo_result_q <= 64'd1;
                            end
`else
                            state_q      <= ACK;
                            amo_ack_q    <= 1'b1;
                            amo_result_q <= 64'd1;
`endif
                        end else begin
                            // AMO_NONE and unused encodings complete without memory access.
                            state_q      <= ACK;
                            amo_ack_q    <= 1'b1;
                            amo_result_q <= 64'd0;
                        end
                    end
                end

                READ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT_RDATA;
                    end
                end

                WAIT_RDATA: begin
                    if (mem_rvalid_i) begin
                        amo_result_q <= old_val_d;
                        if (op_q == AMO_LR) begin
                            state_q   <= ACK;
                            amo_ack_q <= 1'b1;
                        end else begin
                            state_q     <= WRITE;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end

                WRITE: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ACK;
                        amo_ack_q <= 1'b1;
                    end
                end

                ACK: begin
                    state_q      <= IDLE;
                    amo_result_q <= 64'd0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
